// File: rtl/pwm_instr_decoder.sv
// pwm_instr_decoder: receive side of the servo PWM instruction link.
// Measures each high pulse on the synchronised PWM line and classifies it as
// back / stop / forward. A consecutive-match filter decides when the
// published instruction changes. Malformed pulses and a silent line are
// flagged.
module pwm_instr_decoder #(
    parameter int BACK_W  = 115,
    parameter int STOP_W  = 230,
    parameter int FWD_W   = 238,
    parameter int TOL     = 3,
    parameter int MAX_W   = 512,
    parameter int TIMEOUT = 6144,
    parameter int MATCH   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pwm_in,
    output logic [1:0] instr,
    output logic       instr_valid,
    output logic       pulse_err,
    output logic       link_lost
);

    localparam int MCW = (MATCH < 1) ? 1 : $clog2(MATCH + 1);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } state_t;

    // Synchroniser, edge history and start-up fill tracking
    logic             sync1_q, sync2_q, pwm_q;
    logic [1:0]       fill_q, fill_d;
    logic             pwm_s, rise, fall;

    // Pulse measurement
    logic [11:0]      w_q, w_d;
    logic [12:0]      idle_q, idle_d;
    logic             timeout_hit;

    // Pulse-tracking FSM
    state_t           state_q, state_d;
    logic             cls_pend_q, cls_pend_d;
    logic [11:0]      w_cap_q, w_cap_d;
    logic             long_err;

    // Classification and match filter
    logic [1:0]       code;
    logic             code_ok;
    logic [1:0]       cand_q, cand_d;
    logic [MCW-1:0]   match_q, match_d;
    logic [1:0]       instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             link_q, link_d;

    assign pwm_s = sync2_q;
    assign rise  = pwm_s & ~pwm_q;
    assign fall  = ~pwm_s & pwm_q;

    // True when w lies within +/-TOL of a nominal width (inclusive edges)
    function automatic logic in_band(input logic [11:0] w, input int nom);
        int wi;
        wi = int'(w);
        return (wi >= nom - TOL) && (wi <= nom + TOL);
    endfunction

    // Width and idle counters; fill_q marks when the synchroniser holds real
    // line samples after reset, so ARM cannot mistake the reset zeros for a
    // low line in the middle of a pulse
    always_comb begin
        w_d = w_q;
        if (rise) begin
            w_d = 12'd1;
        end else if (pwm_s && (w_q != 12'hFFF)) begin
            w_d = w_q + 12'd1;
        end

        idle_d = idle_q;
        if (rise) begin
            idle_d = 13'd0;
        end else if (idle_q != 13'h1FFF) begin
            idle_d = idle_q + 13'd1;
        end

        timeout_hit = ~rise && (idle_q == 13'(TIMEOUT - 1));
        fill_d      = {fill_q[0], 1'b1};
    end

    // Pulse-tracking FSM: discard pulses in progress, capture width on fall
    always_comb begin
        state_d    = state_q;
        cls_pend_d = 1'b0;
        w_cap_d    = w_cap_q;
        long_err   = 1'b0;
        case (state_q)
            ARM: begin
                if (fill_q[1] && !pwm_s) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d    = WAIT_RISE;
                    cls_pend_d = 1'b1;
                    w_cap_d    = w_q;
                end else if (w_q > 12'(MAX_W)) begin
                    state_d  = ARM;
                    long_err = 1'b1;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // Map the captured width to an instruction code
    always_comb begin
        code    = 2'b11;
        code_ok = 1'b0;
        if (in_band(w_cap_q, BACK_W)) begin
            code    = 2'b10;
            code_ok = 1'b1;
        end else if (in_band(w_cap_q, STOP_W)) begin
            code    = 2'b11;
            code_ok = 1'b1;
        end else if (in_band(w_cap_q, FWD_W)) begin
            code    = 2'b01;
            code_ok = 1'b1;
        end
    end

    // Match filter, status pulses and link supervision; timeout has last say
    always_comb begin
        instr_d = instr_q;
        cand_d  = cand_q;
        match_d = match_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        link_d  = link_q;

        if (rise) begin
            link_d = 1'b0;
        end

        if (long_err) begin
            err_d   = 1'b1;
            match_d = '0;
        end else if (cls_pend_q) begin
            if (code_ok) begin
                valid_d = 1'b1;
                if (code == cand_q) begin
                    if (match_q != MCW'(MATCH)) begin
                        match_d = match_q + MCW'(1);
                    end
                end else begin
                    cand_d  = code;
                    match_d = MCW'(1);
                end
                if (match_d == MCW'(MATCH)) begin
                    instr_d = cand_d;
                end
            end else begin
                err_d   = 1'b1;
                match_d = '0;
            end
        end

        if (timeout_hit) begin
            link_d  = 1'b1;
            instr_d = 2'b11;
            match_d = '0;
        end
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pwm_q      <= 1'b0;
            fill_q     <= 2'b00;
            w_q        <= '0;
            idle_q     <= '0;
            state_q    <= ARM;
            cls_pend_q <= 1'b0;
            w_cap_q    <= '0;
            cand_q     <= 2'b11;
            match_q    <= '0;
            instr_q    <= 2'b11;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            sync1_q    <= pwm_in;
            sync2_q    <= sync1_q;
            pwm_q      <= pwm_s;
            fill_q     <= fill_d;
            w_q        <= w_d;
            idle_q     <= idle_d;
            state_q    <= state_d;
            cls_pend_q <= cls_pend_d;
            w_cap_q    <= w_cap_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            link_q     <= link_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pulse_err   = err_q;
    assign link_lost   = link_q;

endmodule

// File: tb/tb_pwm_instr_decoder.sv
// tb_pwm_instr_decoder: directed pulse-width vectors with hand-computed
// expected instruction, pulse counts, latency and timeout timing.
module tb_pwm_instr_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pwm_in;
    logic [1:0] instr;
    logic       instr_valid;
    logic       pulse_err;
    logic       link_lost;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_valid_cyc = 0;
    int link_rise_cnt = 0;
    int link_cyc = 0;
    logic [1:0] instr_at_link = 2'b00;
    logic link_prev = 1'b0;

    int rise_cyc = 0;
    int fall_cyc = 0;
    int v0, e0;

    pwm_instr_decoder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pwm_in      (pwm_in),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pulse_err   (pulse_err),
        .link_lost   (link_lost)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running cycle count, read by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (instr_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (pulse_err) err_cnt <= err_cnt + 1;
        if (instr_valid && pulse_err) both_cnt <= both_cnt + 1;
        if (link_lost && !link_prev) begin
            link_rise_cnt <= link_rise_cnt + 1;
            link_cyc      <= cyc;
            instr_at_link <= instr;
        end
        link_prev <= link_lost;
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One frame: high for width cycles, then low for low_cycles cycles
    task automatic applyStimulus(input int width, input int low_cycles);
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (width) @(posedge clk);
        #1;
        pwm_in   = 1'b0;
        fall_cyc = cyc;
        repeat (low_cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_instr", 32'(instr), 32'd3);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_err", 32'(pulse_err), 32'd0);
        checkOutput("rst_link", 32'(link_lost), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] stop frames");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(230, 3072 - 230);
            checkOutput("stop_latency", 32'(last_valid_cyc - fall_cyc), 32'd4);
        end
        checkOutput("stop_valid_cnt", 32'(valid_cnt), 32'd4);
        checkOutput("stop_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("stop_instr", 32'(instr), 32'd3);

        $display("[TB] forward, forward, back");
        applyStimulus(238, 200);
        checkOutput("fwd1_instr", 32'(instr), 32'd3);
        applyStimulus(238, 200);
        checkOutput("fwd2_instr", 32'(instr), 32'd1);
        checkOutput("fwd2_latency", 32'(last_valid_cyc - fall_cyc), 32'd4);
        applyStimulus(115, 200);
        checkOutput("back1_instr", 32'(instr), 32'd1);
        checkOutput("fwd_back_valid_cnt", 32'(valid_cnt), 32'd7);

        $display("[TB] tolerance edges");
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(234, 200);
        applyStimulus(111, 200);
        checkOutput("tol_out_err", 32'(err_cnt - e0), 32'd2);
        checkOutput("tol_out_valid", 32'(valid_cnt - v0), 32'd0);
        applyStimulus(233, 200);
        checkOutput("tol_233_valid", 32'(valid_cnt - v0), 32'd1);
        applyStimulus(241, 200);
        checkOutput("tol_241_valid", 32'(valid_cnt - v0), 32'd2);
        checkOutput("tol_err_total", 32'(err_cnt - e0), 32'd2);
        checkOutput("tol_instr", 32'(instr), 32'd1);

        $display("[TB] over-long pulse");
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(600, 200);
        checkOutput("long_err", 32'(err_cnt - e0), 32'd1);
        checkOutput("long_valid", 32'(valid_cnt - v0), 32'd0);
        applyStimulus(115, 200);
        checkOutput("back_a_instr", 32'(instr), 32'd1);
        applyStimulus(115, 200);
        checkOutput("back_b_instr", 32'(instr), 32'd2);
        checkOutput("back_valid", 32'(valid_cnt - v0), 32'd2);

        $display("[TB] link timeout");
        applyStimulus(238, 200);
        applyStimulus(238, 200);
        checkOutput("pre_to_instr", 32'(instr), 32'd1);
        checkOutput("pre_to_link", 32'(link_lost), 32'd0);
        repeat (6000) @(posedge clk);
        #1;
        checkOutput("to_link", 32'(link_lost), 32'd1);
        checkOutput("to_link_events", 32'(link_rise_cnt), 32'd1);
        checkOutput("to_timing", 32'(link_cyc - rise_cyc), 32'd6147);
        checkOutput("to_instr_same_cycle", 32'(instr_at_link), 32'd3);
        checkOutput("to_instr", 32'(instr), 32'd3);
        applyStimulus(238, 200);
        checkOutput("relink_link", 32'(link_lost), 32'd0);
        checkOutput("relink1_instr", 32'(instr), 32'd3);
        applyStimulus(238, 200);
        checkOutput("relink2_instr", 32'(instr), 32'd1);

        $display("[TB] reset mid-pulse");
        v0 = valid_cnt;
        e0 = err_cnt;
        pwm_in = 1'b1;
        repeat (119) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        checkOutput("midrst_instr", 32'(instr), 32'd3);
        checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
        checkOutput("midrst_link", 32'(link_lost), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (118) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("trunc_valid", 32'(valid_cnt - v0), 32'd0);
        checkOutput("trunc_err", 32'(err_cnt - e0), 32'd0);
        checkOutput("trunc_instr", 32'(instr), 32'd3);
        applyStimulus(238, 200);
        applyStimulus(238, 200);
        checkOutput("post_rst_instr", 32'(instr), 32'd1);
        checkOutput("post_rst_valid", 32'(valid_cnt - v0), 32'd2);

        checkOutput("no_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_instr_decoder.md
Name: pwm_instr_decoder

Overview:
- Receive-side counterpart of the servo PWM instruction encoder.
- Samples an incoming servo-style PWM line (frame of 3072 clk cycles, high pulse width encodes a 2-bit drive instruction) and measures each high pulse.
- Classifies the pulse as back, stop or forward and republishes the 2-bit instruction after a consecutive-match filter.
- Sits between the board-to-board link pin and the motion controller; also flags malformed pulses and loss of link.

Parameters:
- BACK_W, 115, nominal high width in cycles for instr 2'b10 (back)
- STOP_W, 230, nominal high width for instr 2'b11 (stop)
- FWD_W, 238, nominal high width for instr 2'b01 (forward)
- TOL, 3, accepted deviation ±TOL cycles, inclusive; must satisfy TOL < (FWD_W-STOP_W)/2
- MAX_W, 512, high widths above this abort as error
- TIMEOUT, 6144, cycles with no rising edge before link is declared lost
- MATCH, 2, consecutive identical valid codes required before instr changes

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pwm_in  in  1  asynchronous PWM line; must be synchronised internally
- instr  out  2  decoded instruction: 10 back, 11 stop, 01 forward
- instr_valid  out  1  one-cycle pulse each time a pulse classifies as a valid code
- pulse_err  out  1  one-cycle pulse for an out-of-tolerance or over-long pulse
- link_lost  out  1  level; high while no rising edge has been seen for TIMEOUT cycles

Behaviour:
- Reset (async assert, sync release): instr=2'b11, instr_valid=0, pulse_err=0, link_lost=0, state=ARM, counters=0, match count=0, both sync flops=0.
- Synchroniser: two flops give pwm_s; pwm_q is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_q
  - fall = ~pwm_s & pwm_q
- Width counter: 12 bits, saturating at 4095. Cleared on rise; increments each cycle pwm_s=1, so w = number of cycles pwm_s was high.
- Idle counter: 13 bits, saturating. Cleared on rise; increments otherwise.
- FSM states:
  - ARM: entered from reset. Waits for pwm_s=0 so a pulse in progress at reset release is discarded. Then go to WAIT_RISE.
  - WAIT_RISE: on rise, go to HIGH.
  - HIGH: on fall, classify w and go to WAIT_RISE. If w reaches MAX_W+1 before a fall, pulse_err=1 for one cycle, match count=0, go to ARM.
- Classification, registered on the cycle after fall is detected:
  - |w-BACK_W|<=TOL gives 10; |w-STOP_W|<=TOL gives 11; |w-FWD_W|<=TOL gives 01.
  - A valid code pulses instr_valid; anything else pulses pulse_err and clears the match count.
  - instr_valid and pulse_err are never high in the same cycle.
- Latency: instr_valid asserts on the 3rd clk edge after the first edge that samples pwm_in low.
- Match filter:
  - Valid code equal to the previous candidate: match count++ (saturating at MATCH). Otherwise candidate=code, match count=1.
  - instr loads the candidate in the same cycle match count reaches MATCH.
  - With MATCH=1, instr updates on every valid pulse.
- Timeout:
  - Idle counter reaching TIMEOUT sets link_lost=1, forces instr=2'b11 in the same cycle, and clears the match count.
  - link_lost clears on the next rise. instr does not change until MATCH new valid codes arrive.
- Simultaneous events: rise and timeout in the same cycle means rise wins and link_lost stays 0.
- Reset mid-pulse: all outputs return to reset values immediately; the partial pulse is ignored via ARM.

Test Plan:
- Reset, then 4 frames of 230-cycle high in 3072-cycle frames -> instr stays 11; instr_valid pulses 4 times, each 3 cycles after the falling edge; pulse_err never asserted.
- Frames with widths 238, 238, 115 -> instr becomes 01 at the 2nd valid pulse; the single 115 does not change instr (match count=1).
- Widths 234 then 111 -> each gives a pulse_err pulse and no instr_valid. Widths 233 and 241 -> classify 11 and 01 (tolerance edges inclusive).
- Hold pwm_in high for 600 cycles -> pulse_err once at w=513, FSM waits in ARM until low, and the next 115-cycle pulses decode normally.
- Drive instr to 01, then hold pwm_in low 6144 cycles -> link_lost=1 and instr=11 on that cycle; the next rise clears link_lost; instr returns to 01 only after 2 valid 238 pulses.
- Assert reset_n low for 1 cycle midway through a 238-cycle pulse -> outputs reset asynchronously; the truncated pulse is discarded, with no instr_valid or pulse_err for it.
